iccm_boot_arbiter: RTL
======================

Name: iccm_boot_arbiter

Overview:
- Owns the single ICCM port and shares it between two requesters: the UART boot loader (word writes) and the core fetch path (the TL-UL SRAM adapter's read requests).
- Sequences boot: holds the core in reset while the image is loaded, releases it after a programmable delay, and supports live reprogramming.
- Reprogramming quiesces outstanding fetches first, then re-asserts core reset.
- Sits between the ICCM controller/adapter and the instruction memory macro.

Parameters:
- AW, 12, ICCM word-address width
- DW, 32, data width
- MAX_OUT, 2, max outstanding core reads (matches adapter Outstanding)
- RELEASE_DLY, 16, cycles between load completion and core reset deassertion (>=1)
- CNT_W, 16, width of write counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ldr_start_i  in  1  pulse: loader begins (re)programming
- ldr_we_i  in  1  loader word-write strobe
- ldr_addr_i  in  AW  loader word address
- ldr_wdata_i  in  DW  loader write data
- ldr_done_i  in  1  pulse: image complete
- core_req_i  in  1  fetch request from adapter
- core_addr_i  in  AW  fetch address
- core_gnt_o  out  1  fetch grant
- core_rvalid_o  out  1  read data valid to adapter
- core_rdata_o  out  DW  read data to adapter
- mem_req_o  out  1  memory request
- mem_we_o  out  4  byte write enables
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data
- mem_rvalid_i  in  1  memory read valid (1-cycle after read req)
- core_rst_o  out  1  active-high reset to core
- boot_busy_o  out  1  high in all states except RUN
- ldr_err_o  out  1  sticky: write dropped (FIFO overflow or wrong state); cleared on ldr_start_i
- wr_count_o  out  CNT_W  words written this session, saturating

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: state=LOAD, core_rst_o=1, boot_busy_o=1, outputs otherwise 0, FIFO empty, counters 0.
- States: LOAD, RELEASE, RUN, QUIESCE.
- LOAD:
  - FIFO head drains to memory, one word per cycle: mem_req_o=1, mem_we_o=4'hF, addr/wdata from FIFO.
  - core_gnt_o=0.
  - ldr_done_i sets done_pend.
  - When done_pend=1 and the FIFO is empty: go RELEASE, load delay counter with RELEASE_DLY, clear done_pend.
- RELEASE:
  - Counter decrements each cycle; at 0 go RUN and drive core_rst_o=0 the same cycle RUN is entered.
  - ldr_start_i here returns to LOAD (core still in reset).
- RUN:
  - core_gnt_o = core_req_i && outstanding<MAX_OUT, combinational.
  - On grant: mem_req_o=1, mem_we_o=0, mem_addr_o=core_addr_i.
  - outstanding increments on grant and decrements on mem_rvalid_i; both in one cycle leaves it unchanged.
  - ldr_start_i goes to QUIESCE.
- QUIESCE:
  - core_gnt_o=0.
  - Returning rvalids are still forwarded.
  - When outstanding==0: core_rst_o=1 and go LOAD.
- Read return: core_rvalid_o=mem_rvalid_i and core_rdata_o=mem_rdata_i, passthrough, in RUN and QUIESCE only; 0 otherwise.
- Loader writes:
  - Accepted into the 2-deep FIFO in LOAD and QUIESCE.
  - A write in RELEASE or RUN, or a write into a full FIFO with no same-cycle pop, is dropped and sets ldr_err_o.
  - Simultaneous push and pop on a full FIFO is accepted.
- ldr_start_i:
  - Clears ldr_err_o and wr_count_o, and done_pend.
  - In LOAD or QUIESCE it is otherwise ignored.
- wr_count_o increments on each FIFO pop to memory and saturates at all-ones.
- ldr_done_i arriving in QUIESCE sets done_pend, which is honoured in LOAD.
- Memory write latency is 0; no memory backpressure.

Decomposition:
- Package iccm_boot_pkg: state enum (LOAD, RELEASE, RUN, QUIESCE), write-entry struct {addr, wdata}.
- Sub-module iccm_wr_fifo: 2-entry FIFO of write entries with push/pop/full/empty and async active-high reset.

Test Plan:
- Reset, 4 loader writes to addr 0..3 (data 0xA0..A3), then ldr_done_i:
  - mem_we_o=4'hF on 4 cycles with matching addr/data.
  - core_rst_o drops exactly RELEASE_DLY cycles after the last write.
  - wr_count_o=4.
- RUN, core_req_i held high with mem_rvalid_i delayed, so two grants are issued before any rvalid returns:
  - Third request not granted until an rvalid returns.
  - core_rdata_o passes 0xDEADBEEF.
- RUN with 2 reads outstanding, then ldr_start_i:
  - core_gnt_o=0 immediately.
  - core_rst_o rises the cycle after the second rvalid returns.
  - wr_count_o=0.
- QUIESCE, 3 loader writes back to back:
  - First two buffered, third dropped, ldr_err_o=1.
  - After LOAD entry, both buffered words written in order.
- ldr_done_i with FIFO holding 2 entries: RELEASE entered only after both pops.
- Loader write during RUN: no mem write, ldr_err_o=1, cleared by the next ldr_start_i.

Source files
------------

// File: rtl/iccm_boot_pkg.sv
// Shared types for the ICCM boot arbiter: boot sequencing states and the
// loader write-entry record buffered ahead of the memory port.
package iccm_boot_pkg;

  localparam int ICCM_AW = 12;
  localparam int ICCM_DW = 32;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    QUIESCE  = 2'd3
  } boot_state_e;

  typedef struct packed {
    logic [ICCM_AW-1:0] addr;
    logic [ICCM_DW-1:0] wdata;
  } wr_entry_t;

endpackage

// File: rtl/iccm_wr_fifo.sv
// Two-entry FIFO of loader write entries. Pushing into a full FIFO is only
// taken when a pop happens in the same cycle; popping an empty FIFO is ignored.
module iccm_wr_fifo
  import iccm_boot_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  wr_entry_t din_i,
  output wr_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  wr_entry_t  ent_q [2];
  wr_entry_t  ent_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = ent_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    ent_d = ent_q;
    if (do_push) ent_d[wr_ptr_q] = din_i;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/iccm_boot_arbiter.sv
// Shares the single ICCM port between the UART boot loader and core fetch,
// and sequences core reset across image load, release delay and reprogramming.
module iccm_boot_arbiter
  import iccm_boot_pkg::*;
#(
  parameter int AW          = ICCM_AW,
  parameter int DW          = ICCM_DW,
  parameter int MAX_OUT     = 2,
  parameter int RELEASE_DLY = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ldr_start_i,
  input  logic             ldr_we_i,
  input  logic [AW-1:0]    ldr_addr_i,
  input  logic [DW-1:0]    ldr_wdata_i,
  input  logic             ldr_done_i,
  input  logic             core_req_i,
  input  logic [AW-1:0]    core_addr_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  output logic [DW-1:0]    core_rdata_o,
  output logic             mem_req_o,
  output logic [3:0]       mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i,
  input  logic             mem_rvalid_i,
  output logic             core_rst_o,
  output logic             boot_busy_o,
  output logic             ldr_err_o,
  output logic [CNT_W-1:0] wr_count_o
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int DLY_W = $clog2(RELEASE_DLY + 1);

  boot_state_e      state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_pend_q, done_pend_d;

  logic             leave_load;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             wr_ok, wr_drop;
  wr_entry_t        push_ent, fifo_head;

  assign push_ent.addr  = ldr_addr_i;
  assign push_ent.wdata = ldr_wdata_i;

  iccm_wr_fifo u_wr_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (push_ent),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      dly_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      done_pend_q <= done_pend_d;
    end
  end

  // A start pulse in LOAD cancels a pending completion rather than racing it.
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    leave_load = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (done_pend_q && fifo_empty && !ldr_start_i) begin
          state_d    = RELEASE;
          dly_d      = DLY_W'(RELEASE_DLY);
          leave_load = 1'b1;
        end
      end
      RELEASE: begin
        if (ldr_start_i) begin
          state_d = LOAD;
        end else begin
          dly_d = dly_q - 1'b1;
          if (dly_q == DLY_W'(1)) state_d = RUN;
        end
      end
      RUN: begin
        if (ldr_start_i) state_d = QUIESCE;
      end
      QUIESCE: begin
        if (out_q == '0) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    core_rst_o    = 1'b1;
    boot_busy_o   = 1'b1;
    mem_req_o     = 1'b0;
    mem_we_o      = 4'h0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    fifo_pop      = 1'b0;
    unique case (state_q)
      LOAD: begin
        fifo_pop = !fifo_empty;
        if (fifo_pop) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 4'hF;
          mem_addr_o  = fifo_head.addr;
          mem_wdata_o = fifo_head.wdata;
        end
      end
      RUN: begin
        core_rst_o    = 1'b0;
        boot_busy_o   = 1'b0;
        core_gnt_o    = core_req_i && !ldr_start_i && (out_q < OUT_W'(MAX_OUT));
        core_rvalid_o = mem_rvalid_i;
        core_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
        if (core_gnt_o) begin
          mem_req_o  = 1'b1;
          mem_addr_o = core_addr_i;
        end
      end
      QUIESCE: begin
        // Core stays out of reset until its last fetch has returned.
        core_rst_o    = (out_q == '0);
        core_rvalid_o = mem_rvalid_i;
        core_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ok     = (state_q == LOAD) || (state_q == QUIESCE);
    fifo_push = ldr_we_i && wr_ok && (!fifo_full || fifo_pop);
    wr_drop   = ldr_we_i && !fifo_push;

    err_d = (ldr_start_i ? 1'b0 : err_q) | wr_drop;

    cnt_d = ldr_start_i ? '0 : cnt_q;
    if (fifo_pop && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;

    done_pend_d = (ldr_start_i ? 1'b0 : done_pend_q) | ldr_done_i;
    if (leave_load) done_pend_d = 1'b0;

    out_d = out_q;
    if (core_gnt_o) out_d = out_d + OUT_W'(1);
    if (mem_rvalid_i && (out_q != '0)) out_d = out_d - OUT_W'(1);
  end

  assign ldr_err_o  = err_q;
  assign wr_count_o = cnt_q;

endmodule
